// File: rtl/shift_in_word_capture_reg_pkg.sv
// Shared constants for the serial shift registers: bit-order encoding and
// assembly state encoding of the receive side.
package shift_in_word_capture_reg_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

endpackage

// File: rtl/word_hold_stage.sv
// One-entry valid/ready output buffer. A load into a full buffer that is not
// being drained in the same cycle is dropped and flagged with a one-cycle overrun.
module word_hold_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                // Slot is free if empty or its current word leaves this cycle.
                if (!word_valid || word_ready) begin
                    word_out   <= load_word;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_in_word_capture_reg.sv
// Serial-in/parallel-out receiver: assembles WIDTH qualified bits into a word
// (MSB-first or LSB-first, chosen at the first bit) and hands it to a 1-entry buffer.
module shift_in_word_capture_reg
    import shift_in_word_capture_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             shift_dir,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    asm_state_t       state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] count_reg;
    logic             dir_reg;
    logic             eff_dir;
    logic             complete;

    // The first bit of a word uses the live direction; later bits the latched one.
    always_comb begin
        eff_dir = (state == IDLE) ? shift_dir : dir_reg;
        if (eff_dir == DIR_LSB_FIRST) begin
            shifted = {serial_in, shift_reg[WIDTH-1:1]};
        end else begin
            shifted = {shift_reg[WIDTH-2:0], serial_in};
        end
        complete = serial_valid && !flush && (state == COLLECT) && (count_reg == LAST_BIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            dir_reg   <= DIR_MSB_FIRST;
        end else if (flush) begin
            state     <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
        end else if (serial_valid) begin
            case (state)
                IDLE: begin
                    dir_reg   <= shift_dir;
                    shift_reg <= shifted;
                    count_reg <= CNT_W'(1);
                    state     <= COLLECT;
                end
                COLLECT: begin
                    if (count_reg == LAST_BIT) begin
                        shift_reg <= '0;
                        count_reg <= '0;
                        state     <= IDLE;
                    end else begin
                        shift_reg <= shifted;
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign bit_count = count_reg;

    word_hold_stage #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (complete),
        .load_word  (shifted),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_shift_in_word_capture_reg.sv
// Bench for shift_in_word_capture_reg: directed scenarios plus random traffic,
// all checked every cycle against a bit-list reference model.
module tb_shift_in_word_capture_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         serial_in, serial_valid, shift_dir, flush, word_ready;
    logic [W-1:0] word_out;
    logic         word_valid, overrun;
    logic [3:0]   bit_count;

    int tests_run = 0;
    int tests_failed = 0;
    string phase = "reset";

    // Reference model state
    bit           m_bits[$];
    bit           m_dir;
    logic [W-1:0] m_word;
    logic         m_valid;
    logic         m_ovr;

    always #5 clk = ~clk;

    shift_in_word_capture_reg #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .shift_dir    (shift_dir),
        .flush        (flush),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .overrun      (overrun),
        .bit_count    (bit_count)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b0;
        m_word  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Word value from the collected bit list: MSB-first means the first bit is
    // the most significant; LSB-first means bit i lands at position i.
    function automatic logic [W-1:0] assemble(input bit dir);
        logic [W-1:0] acc = '0;
        for (int i = 0; i < W; i++) begin
            if (dir == 1'b0) acc = {acc[W-2:0], m_bits[i]};
            else acc[i] = m_bits[i];
        end
        return acc;
    endfunction

    task automatic model_step(input bit sv, input bit b, input bit d, input bit fl, input bit rdy);
        bit           done = 1'b0;
        logic [W-1:0] nw = '0;
        if (fl) begin
            m_bits.delete();
        end else if (sv) begin
            if (m_bits.size() == 0) m_dir = d;
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                nw = assemble(m_dir);
                done = 1'b1;
                m_bits.delete();
            end
        end
        m_ovr = 1'b0;
        if (done) begin
            if (!m_valid || rdy) begin
                m_word  = nw;
                m_valid = 1'b1;
                $display("[TB] %s: word 0x%02h dir %0d accepted", phase, nw, m_dir);
            end else begin
                m_ovr = 1'b1;
                $display("[TB] %s: word 0x%02h dir %0d dropped (overrun)", phase, nw, m_dir);
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_value("word_valid", word_valid, m_valid);
        check_value("word_out", word_out, m_word);
        check_value("overrun", overrun, m_ovr);
        check_value("bit_count", bit_count, m_bits.size());
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic cycle(input bit sv, input bit b, input bit d, input bit fl, input bit rdy);
        serial_valid = sv;
        serial_in    = b;
        shift_dir    = d;
        flush        = fl;
        word_ready   = rdy;
        @(posedge clk);
        model_step(sv, b, d, fl, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit d, input int gap,
                             input bit rdy, input bit rdy_last);
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, (d == 1'b0) ? w[W-1-i] : w[i], d, 1'b0, (i == W-1) ? rdy_last : rdy);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, d, 1'b0, rdy);
        end
    endtask

    initial begin
        reset = 1'b1;
        serial_in = 0; serial_valid = 0; shift_dir = 0; flush = 0; word_ready = 0;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        phase = "t1_msb";
        send_word(8'hA5, 1'b0, 0, 1'b0, 1'b0);
        check_value("t1_word", word_out, 8'hA5);
        cycle(0, 0, 0, 0, 1);
        check_value("t1_drained", word_valid, 1'b0);

        phase = "t2_lsb";
        send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        check_value("t2_word", word_out, 8'hA5);
        cycle(0, 0, 0, 0, 1);
        phase = "t2_toggle";
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] w = 8'hA5;
            cycle(1'b1, w[i], (i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        check_value("t2_toggle_word", word_out, 8'hA5);
        cycle(0, 0, 0, 0, 1);

        phase = "t3_gapped";
        send_word(8'h3C, 1'b0, 2, 1'b0, 1'b0);
        check_value("t3_word", word_out, 8'h3C);
        cycle(0, 0, 0, 0, 1);

        phase = "t4_overrun";
        send_word(8'h11, 1'b0, 0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 0, 1'b0, 1'b0);
        check_value("t4_ovr_pulse", overrun, 1'b1);
        check_value("t4_kept", word_out, 8'h11);
        cycle(0, 0, 0, 0, 0);
        check_value("t4_ovr_once", overrun, 1'b0);
        phase = "t4_replace";
        send_word(8'h22, 1'b0, 0, 1'b0, 1'b1);
        check_value("t4_new", word_out, 8'h22);
        check_value("t4_no_ovr", overrun, 1'b0);
        cycle(0, 0, 0, 0, 1);

        phase = "t5_flush";
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_value("t5_count", bit_count, 4'd0);
        send_word(8'hF0, 1'b0, 0, 1'b0, 1'b0);
        check_value("t5_word", word_out, 8'hF0);

        phase = "t6_reset";
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        send_word(8'h81, 1'b0, 0, 1'b0, 1'b0);
        check_value("t6_word", word_out, 8'h81);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
